mips_fetch_unit: RTL
====================

# mips_fetch_unit

Instruction fetch stage sitting directly upstream of the synthesizable dual-port memory: drives bus 0's address, consumes its 1-cycle-latency read data, and delivers instructions with their PCs to decode over a valid/ready handshake. A small response buffer absorbs decode back-pressure without re-reading memory. Branch/jump redirects flush in-flight and buffered words.

## Interface
- `N`, 32: data/address width.
- `RESET_PC`, 32'h4000_0000: first fetch address, the base of instruction space.
- `BUF_DEPTH`, 2: response buffer entries, ≥2. 2 gives full throughput.

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_addr` out N: to memory `addr0`. Driven straight from the `fetch_pc` register.
- `mem_wr_ena` out 1: to memory `wr_ena0`. Constant 0.
- `mem_rdata` in N: from memory `dout0`. Data for the address presented in the previous cycle.
- `redirect_valid` in 1: load a new PC this cycle.
- `redirect_pc` in N: target PC.
- `out_valid` out 1: an instruction is available.
- `out_ready` in 1: decode accepts.
- `out_instr` out N: instruction word.
- `out_pc` out N: PC of `out_instr`.
- `out_pc_plus4` out N: `out_pc + 4`, modulo 2^N.
- `fault` out 1: sticky misaligned-redirect flag.

## Operation
- **State:** `fetch_pc`, `inflight` (1 bit), `inflight_pc`, a FIFO of {pc, instr} with `count`, and `fault`.
- **Memory read:** memory reads `fetch_pc` every cycle.
- **Issue condition:** a read counts as issued when
  - `!rst`, `!redirect_valid` and `!fault`, and
  - `count + inflight − deq < BUF_DEPTH`, where `deq = out_valid & out_ready`.
- **On issue:**
  - `inflight_pc <= fetch_pc`
  - `fetch_pc <= fetch_pc + 4`
  - `inflight <= 1`
- **Otherwise:** `inflight <= 0` and `fetch_pc` holds. The unused read is harmless.
- **Enqueue:** when `inflight` is 1, enqueue {`inflight_pc`, `mem_rdata`} this cycle.
- **Outputs:** `out_valid = (count != 0)`. `out_*` show the FIFO head. Dequeue on `deq`.
- **Simultaneous enqueue and dequeue:** both happen, so `count` is unchanged. The issue condition guarantees the FIFO never overflows.
- **Redirect (aligned):**
  - `fetch_pc <= redirect_pc`, `inflight <= 0`, FIFO cleared.
  - The `mem_rdata` arriving this cycle is discarded.
  - A head accepted (`deq`) in the same cycle counts as transferred. Decode must squash it itself.
- **Redirect with `redirect_pc[1:0] != 0`:**
  - `fault <= 1`, FIFO cleared, `inflight <= 0`, `fetch_pc` unchanged.
  - No further issues until `rst`.
  - Further redirects are ignored while `fault` is set.
- **No alignment or region checks on sequential PCs.** Wrap past 2^N−4 to 0 is plain modulo.
- **Reset values:**
  - `fetch_pc = RESET_PC`, `mem_addr = RESET_PC`, `mem_wr_ena = 0`
  - `inflight = 0`, `count = 0`, `out_valid = 0`, `fault = 0`
  - `out_instr`, `out_pc`, `out_pc_plus4` = 0
- **Reset mid-stream:** FIFO and in-flight word are discarded. Restart is identical to power-up.

## Timing
- **Fetch latency:** issue in cycle t → data on `mem_rdata` in t+1 → FIFO entry visible, `out_valid=1`, in t+2.
- **After reset:** first cycle with `rst=0` is cycle 0. `out_valid=1` with `out_pc=RESET_PC` in cycle 2.
- **Redirect:** `redirect_valid` in cycle t → `mem_addr=redirect_pc` in t+1 → `out_valid=1` with `out_pc=redirect_pc` in t+3. `out_valid=0` in t+1 and t+2.
- **Steady state:** with `out_ready=1` continuously, one instruction per cycle, PCs consecutive by 4.
- **Back-pressure:** `out_ready` low → outputs held stable and head not advanced. At most `BUF_DEPTH` words buffered, no duplicates or losses. Throughput resumes the cycle `out_ready` returns.
- **No combinational input→output paths** except through the FIFO head selection. `mem_addr` is purely registered.

## Structure
- `I_START_ADDRESS` and default `RESET_PC` come from the shared memory-space defines include.
- One sub-module, `fetch_resp_fifo`: synchronous FIFO of {pc, instr}, depth `BUF_DEPTH`, with `push`, `pop`, `clear`, `count` and a head-output port.
- Top level holds the PC/issue logic.

## Test plan
- **Reset release:** `rst` high 3 cycles, `out_ready=1` → `out_valid` first high in cycle 2 with `out_pc=0x4000_0000`, `out_pc_plus4=0x4000_0004`, then `0x4000_0004`, `0x4000_0008` on consecutive cycles; `mem_wr_ena` always 0.
- **Back-pressure:** stream, drop `out_ready` 5 cycles at `out_pc=0x4000_0010` → outputs frozen at `0x4000_0010`, `count≤2`; on release PCs `0x10, 0x14, 0x18…` with none skipped or repeated.
- **Redirect:** `redirect_valid` with `0x4000_0100` mid-stream at cycle t → `out_valid=0` at t+1, t+2; `out_pc=0x4000_0100` at t+3; no pre-redirect PC appears afterward.
- **Redirect collisions:**
  - redirect coinciding with `deq` and a full FIFO → FIFO empty at t+1, next output `redirect_pc`;
  - back-to-back redirects `0x4000_0200` then `0x4000_0300` → first output `0x4000_0300`.
- **Misaligned redirect:** `redirect_pc=0x4000_0102` → `fault=1` at t+1, `out_valid=0` forever, `mem_addr` frozen; then `rst` → `fault=0`, normal restart at `RESET_PC`.
- **Memory-model check:** use a 1-cycle-latency model at `0x4000_0000`, filled with data = address; check `out_instr == out_pc` for every transfer. Randomize `out_ready` over 2000 cycles.

Source files
------------

// File: rtl/mips_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: instruction-space base
// address and PC helpers.
package mips_fetch_unit_pkg;

    localparam logic [31:0] I_START_ADDRESS = 32'h4000_0000;

    function automatic logic is_word_aligned(input logic [1:0] pc_lsbs);
        return (pc_lsbs == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_resp_fifo.sv
// Response buffer between memory read data and decode: a small synchronous
// FIFO of {pc, instr} pairs with a flush input and a combinational head.
module fetch_resp_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [N-1:0]     i_pc,
    input  logic [N-1:0]     i_instr,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output logic [N-1:0]     o_head_pc,
    output logic [N-1:0]     o_head_instr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]     r_pc    [DEPTH];
    logic [N-1:0]     r_instr [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            if (i_push && !i_pop)
                r_count <= r_count + CNT_W'(1);
            else if (i_pop && !i_push)
                r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage is data only; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_pc[r_wr_ptr]    <= i_pc;
            r_instr[r_wr_ptr] <= i_instr;
        end
    end

    assign o_count      = r_count;
    assign o_head_pc    = r_pc[r_rd_ptr];
    assign o_head_instr = r_instr[r_rd_ptr];

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: drives a 1-cycle-latency memory port from the PC
// register and hands {pc, instr} to decode through a small response buffer.
module mips_fetch_unit
    import mips_fetch_unit_pkg::*;
#(
    parameter int           N         = 32,
    parameter logic [N-1:0] RESET_PC  = N'(I_START_ADDRESS),
    parameter int           BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] mem_addr,
    output logic         mem_wr_ena,
    input  logic [N-1:0] mem_rdata,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_instr,
    output logic [N-1:0] out_pc,
    output logic [N-1:0] out_pc_plus4,
    output logic         fault
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [N-1:0]     r_fetch_pc;
    logic [N-1:0]     r_inflight_pc;
    logic             r_inflight;
    logic             r_fault;

    logic             w_deq;
    logic             w_flush;
    logic             w_push;
    logic             w_issue;
    logic             w_room;
    logic [OCC_W-1:0] w_occ;
    logic [CNT_W-1:0] w_count;
    logic [N-1:0]     w_head_pc;
    logic [N-1:0]     w_head_instr;

    assign out_valid = (w_count != '0);
    assign w_deq     = out_valid & out_ready;
    // Redirects seen while faulted are ignored entirely, including the flush.
    assign w_flush   = redirect_valid & ~r_fault;
    assign w_push    = r_inflight & ~w_flush;

    // Buffer slots already promised: stored words plus the one in flight,
    // less the head leaving this cycle.
    assign w_occ   = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_deq);
    assign w_room  = (w_occ < OCC_W'(BUF_DEPTH));
    assign w_issue = ~rst & ~redirect_valid & ~r_fault & w_room;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_fault    <= 1'b0;
        end else if (w_flush) begin
            r_inflight <= 1'b0;
            if (is_word_aligned(redirect_pc[1:0]))
                r_fetch_pc <= redirect_pc;
            else
                r_fault <= 1'b1;
        end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + N'(4);
            r_inflight <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) r_inflight_pc <= r_fetch_pc;
    end

    fetch_resp_fifo #(
        .N     (N),
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_resp_fifo (
        .clk          (clk),
        .i_clear      (rst | w_flush),
        .i_push       (w_push),
        .i_pc         (r_inflight_pc),
        .i_instr      (mem_rdata),
        .i_pop        (w_deq),
        .o_count      (w_count),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr)
    );

    // Head fields read as zero whenever the buffer is empty.
    assign out_pc       = out_valid ? w_head_pc : '0;
    assign out_instr    = out_valid ? w_head_instr : '0;
    assign out_pc_plus4 = out_valid ? (w_head_pc + N'(4)) : '0;

    assign mem_addr   = r_fetch_pc;
    assign mem_wr_ena = 1'b0;
    assign fault      = r_fault;

endmodule
